// File: rtl/lau_pkg.sv
// Shared library package: performance selector used by the counter and Gray blocks.
package lau_pkg;

    typedef enum logic {
        FAST  = 1'b0,
        SMALL = 1'b1
    } speed_e;

endpackage

// File: rtl/gray_ptr_counter_bin2gray.sv
// Bin2Gray: combinational binary-to-Gray conversion, G[i] = B[i+1] ^ B[i], MSB passed through.
module Bin2Gray
    import lau_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter speed_e      speed = FAST
) (
    input  logic [width-1:0] B,
    output logic [width-1:0] G
);

    // Both forms are the same function; SMALL keeps the per-bit structure visible to the mapper.
    if (speed == FAST) begin : g_fast
        assign G = B ^ (B >> 1);
    end else begin : g_small
        assign G[width-1] = B[width-1];
        for (genvar i = 0; i < int'(width) - 1; i++) begin : g_bit
            assign G[i] = B[i+1] ^ B[i];
        end
    end

endmodule

// File: rtl/gray_ptr_counter.sv
// Binary pointer counter with flop-direct Gray output for async FIFO pointers.
// Define GRAY_PTR_DOWN_EN to add the dn_i port and decrement support.
module gray_ptr_counter
    import lau_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter speed_e      speed = FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [width-1:0] ld_val_i,
`ifdef GRAY_PTR_DOWN_EN
    input  logic             dn_i,
`endif
    input  logic             en_i,
    output logic [width-1:0] bin_o,
    output logic [width-1:0] gray_o,
    output logic             wrap_o
);

    logic [width-1:0] r_bin;
    logic [width-1:0] r_gray;
    logic             r_wrap;
    logic [width-1:0] w_cnt_n;
    logic [width-1:0] w_gray_n;
    logic             w_wrap_n;

    // Priority clr > ld > en; a wrap only comes from a counting step.
    always_comb begin
        w_cnt_n  = r_bin;
        w_wrap_n = 1'b0;
        if (clr_i) begin
            w_cnt_n = '0;
        end else if (ld_i) begin
            w_cnt_n = ld_val_i;
        end else if (en_i) begin
`ifdef GRAY_PTR_DOWN_EN
            if (dn_i) begin
                w_cnt_n  = r_bin - 1'b1;
                w_wrap_n = (r_bin == '0);
            end else begin
                w_cnt_n  = r_bin + 1'b1;
                w_wrap_n = &r_bin;
            end
`else
            w_cnt_n  = r_bin + 1'b1;
            w_wrap_n = &r_bin;
`endif
        end
    end

    // Gray is converted from the next count so gray_o is a pure flop output.
    Bin2Gray #(
        .width (width),
        .speed (speed)
    ) u_bin2gray (
        .B (w_cnt_n),
        .G (w_gray_n)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_cnt_n;
            r_gray <= w_gray_n;
            r_wrap <= w_wrap_n;
        end
    end

    assign bin_o  = r_bin;
    assign gray_o = r_gray;
    assign wrap_o = r_wrap;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Directed bench for gray_ptr_counter at width 4; covers the decrement path when GRAY_PTR_DOWN_EN is defined.
module tb_gray_ptr_counter;
    import lau_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] ld_val = '0;
    logic         en = 1'b0;
    logic         dn = 1'b0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    int n_checks = 0;
    int n_pass   = 0;

    gray_ptr_counter #(
        .width (W),
        .speed (FAST)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (clr),
        .ld_i     (ld),
        .ld_val_i (ld_val),
`ifdef GRAY_PTR_DOWN_EN
        .dn_i     (dn),
`endif
        .en_i     (en),
        .bin_o    (bin),
        .gray_o   (gray),
        .wrap_o   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] eb, input logic [W-1:0] eg,
                             input logic ew);
        check({tag, ".bin"},  32'(bin),  32'(eb));
        check({tag, ".gray"}, 32'(gray), 32'(eg));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    logic [W-1:0] exp_bin;
    logic [W-1:0] prev_gray;
    logic [W-1:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    initial begin
        // Reset asserted with en high: outputs must be zero before any edge.
        en = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_out("rst_async", 4'h0, 4'h0, 1'b0);
        step();
        check_out("rst_hold", 4'h0, 4'h0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step(); check_out("first1", 4'h1, 4'b0001, 1'b0);
        step(); check_out("first2", 4'h2, 4'b0011, 1'b0);
        step(); check_out("first3", 4'h3, 4'b0010, 1'b0);

        // Full revolution from zero.
        clr = 1'b1;
        step(); check_out("clr0", 4'h0, 4'h0, 1'b0);
        clr = 1'b0;
        exp_bin = '0;
        for (int i = 0; i < 16; i++) begin
            prev_gray = gray;
            step();
            exp_bin = exp_bin + 1'b1;
            check_out($sformatf("cyc%0d", i), exp_bin, gray_tab[exp_bin], exp_bin == 4'h0);
            check($sformatf("ham%0d", i), $countones(gray ^ prev_gray), 1);
        end

        // Load beats en, clear beats everything; wrap pulse is gone.
        ld = 1'b1; ld_val = 4'hA; en = 1'b1;
        step(); check_out("load_a", 4'hA, 4'b1111, 1'b0);
        clr = 1'b1;
        step(); check_out("clr_all", 4'h0, 4'h0, 1'b0);
        clr = 1'b0;

        // Loading into zero from all-ones is not a wrap.
        ld_val = 4'hF;
        step(); check_out("load_f", 4'hF, 4'b1000, 1'b0);
        ld_val = 4'h0;
        step(); check_out("load_0", 4'h0, 4'h0, 1'b0);

        // Hold at 5.
        ld_val = 4'h5;
        step();
        ld = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); check_out($sformatf("hold%0d", i), 4'h5, 4'b0111, 1'b0);
        end

        // Asynchronous reset between edges at count 9.
        ld = 1'b1; ld_val = 4'h9;
        step(); check_out("load_9", 4'h9, 4'b1101, 1'b0);
        ld = 1'b0; en = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_out("rst_mid", 4'h0, 4'h0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step(); check_out("post_rst", 4'h1, 4'b0001, 1'b0);

`ifdef GRAY_PTR_DOWN_EN
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1; dn = 1'b1;
        step(); check_out("dn_wrap", 4'hF, 4'b1000, 1'b1);
        step(); check_out("dn_e", 4'hE, 4'b1001, 1'b0);
        en = 1'b0;
        step(); check_out("dn_idle", 4'hE, 4'b1001, 1'b0);
        ld = 1'b1; ld_val = 4'h3; en = 1'b1;
        step(); check_out("dn_ld", 4'h3, 4'b0010, 1'b0);
        ld = 1'b0; dn = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
